// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the control/datapath and the
// multiply/divide unit.
//   start, op, a, b : request (driven by master)
//   busy, done      : handshake status (driven by slave)
//   hi, lo          : HI/LO register contents (driven by slave)
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (output start, op, a, b, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning the HI/LO pair.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - muldiv_unit_if.slave (start/op/a/b in, busy/done/hi/lo out)
// op: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored.
// Iterative shift-add multiply and restoring divide, 33 cycles busy.
// Optional macro MULDIV_FAST_MUL_EN: MULT/MULTU complete in one cycle through
// a combinational multiplier; divide stays iterative.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input logic          clk,
   input logic          rst,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;     // mul: {partial hi, product low bits}; div: {remainder, quotient}
   logic [XLEN-1:0]   op_a;    // multiplicand, or dividend shifting out MSB first
   logic [XLEN-1:0]   op_b;    // multiplier shifting out LSB first, or divisor
   logic              neg_q;   // negate product / quotient
   logic              neg_r;   // negate remainder
   logic              is_div;
   logic              div0;
   logic              busy_r;
   logic              done_r;
   logic [XLEN-1:0]   hi_r;
   logic [XLEN-1:0]   lo_r;

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

   // Operand magnitudes: op[0]=0 selects the signed variant.
   logic            sgn;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   assign sgn   = ~bus.op[0];
   assign a_mag = (sgn && bus.a[XLEN-1]) ? -bus.a : bus.a;
   assign b_mag = (sgn && bus.b[XLEN-1]) ? -bus.b : bus.b;

   // Multiply step: add multiplicand into upper half if current multiplier
   // bit is set, then shift the whole accumulator right with the carry.
   logic [XLEN:0] mul_sum;
   assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (op_b[0] ? op_a : {XLEN{1'b0}})};

   // Divide step: bring in the next dividend bit; the 33-bit partial
   // remainder is compared against the divisor. When the trial succeeds the
   // result fits in XLEN bits, so the low bits of the difference suffice.
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN-1:0] div_rem;
   assign div_shift = {acc[2*XLEN-1:XLEN], op_a[XLEN-1]};
   assign div_ge    = div_shift >= {1'b0, op_b};
   assign div_rem   = div_ge ? (div_shift[XLEN-1:0] - op_b) : div_shift[XLEN-1:0];

   // Sign correction. A zero divisor leaves the remainder equal to |a|, so
   // the remainder sign fix already yields hi=a; only lo needs forcing.
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix;
   logic [XLEN-1:0]   rem_fix;
   assign prod_fix = neg_q ? -acc : acc;
   assign quot_fix = div0 ? {XLEN{1'b1}} : (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
   assign rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

`ifdef MULDIV_FAST_MUL_EN
   // Low 2*XLEN bits of the product are identical for signed and unsigned
   // once the operands are extended to full width.
   logic [2*XLEN-1:0] ax;
   logic [2*XLEN-1:0] bx;
   logic [2*XLEN-1:0] fast_prod;
   assign ax        = {{XLEN{sgn & bus.a[XLEN-1]}}, bus.a};
   assign bx        = {{XLEN{sgn & bus.b[XLEN-1]}}, bus.b};
   assign fast_prod = ax * bx;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         is_div <= 1'b0;
         div0   <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     OP_MTHI: hi_r <= bus.a;
                     OP_MTLO: lo_r <= bus.a;
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
`ifdef MULDIV_FAST_MUL_EN
                        if (!bus.op[1]) begin
                           {hi_r, lo_r} <= fast_prod;
                           done_r       <= 1'b1;
                        end else begin
`else
                        begin
`endif
                           op_a   <= a_mag;
                           op_b   <= b_mag;
                           neg_q  <= sgn & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                           neg_r  <= sgn & bus.a[XLEN-1];
                           is_div <= bus.op[1];
                           div0   <= bus.op[1] && (bus.b == '0);
                           acc    <= '0;
                           cnt    <= '0;
                           busy_r <= 1'b1;
                           state  <= CALC;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            CALC: begin
               if (is_div) begin
                  acc  <= {div_rem, acc[XLEN-2:0], div_ge};
                  op_a <= {op_a[XLEN-2:0], 1'b0};
               end else begin
                  acc  <= {mul_sum, acc[XLEN-1:1]};
                  op_b <= {1'b0, op_b[XLEN-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == {CW{1'b1}})
                  state <= FIX;
            end
            FIX: begin
               if (is_div) begin
                  hi_r <= rem_fix;
                  lo_r <= quot_fix;
               end else begin
                  {hi_r, lo_r} <= prod_fix;
               end
               busy_r <= 1'b0;
               done_r <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit for the MIPS datapath, owning the HI/LO register pair.
- Sits downstream of the ALU operand-select muxes: rs/rt values are a and b.
- Feeds the writeback result mux via hi/lo for MFHI/MFLO.
- Busy/done handshake lets the control unit stall the PC register while an operation is in flight.

Parameters:
- XLEN, 32, operand width. Only 32 is supported; it is a parameter for readability only.

Ports:
- clk    input   1      clock
- rst    input   1      reset, asynchronous, active-high
- start  input   1      request; sampled only in IDLE
- op     input   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- a      input   32     rs operand (multiplicand / dividend / MTHI-MTLO source)
- b      input   32     rt operand (multiplier / divisor)
- busy   output  1      operation in flight; control stalls on it
- done   output  1      one-cycle pulse: hi/lo hold the new result
- hi     output  32     HI register
- lo     output  32     LO register

Behaviour:
- Reset: rst high forces the following, asynchronously:
  - state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
  - An in-flight operation is discarded and its result is never written.
  - Reset has priority over all other events.
- FSM states: IDLE, CALC, FIX.
  - IDLE -> CALC on start with op in {MULT, MULTU, DIV, DIVU}.
  - CALC -> FIX after 32 iterations.
  - FIX -> IDLE, always.
- Accept edge (E0): start && IDLE && multiply/divide op.
  - Latch operand magnitudes; signed ops take the two's-complement absolute value.
  - Latch result sign flags, clear the 64-bit accumulator, counter=0, busy=1.
- CALC, edges E1..E32: one iteration per edge, counter increments, state leaves CALC when counter reaches 31.
  - Multiply: shift-add, one multiplier bit per edge, LSB first.
  - Divide: restoring division, one quotient bit per edge, MSB first; remainder is 33 bits wide for the trial subtract.
- FIX, edge E33:
  - Apply sign correction and write hi/lo.
  - busy falls to 0; done=1 for exactly one cycle (after E33).
  - State returns to IDLE.
- Total latency: start sampled at E0, result visible after E33; busy high for 33 cycles.
- Result mapping:
  - Multiply: {hi,lo} = full 64-bit product. Product is negated if sign(a)^sign(b) for MULT.
  - Divide: lo = quotient, hi = remainder.
  - DIV signs: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- MTHI/MTLO:
  - With start in IDLE, write a into hi or lo on the same edge.
  - busy stays 0; done is not pulsed.
- Ignored requests (no effect on state or outputs):
  - start while busy, including during FIX.
  - Reserved op codes.
  - hi/lo hold their values during CALC; they are written only in FIX or by MTHI/MTLO.
- Boundary cases:
  - Divide by zero (b=0, DIV or DIVU): hi=a, lo=0xFFFFFFFF; latency unchanged.
  - Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0.
  - MULT 0x80000000 * 0x80000000: {hi,lo} = 0x40000000_00000000.
  - start asserted in the same cycle as done: accepted, since the FSM is in IDLE; the back-to-back operation begins with no gap.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle combinational 64-bit multiply.
  - On the accept edge, hi/lo are written; busy never asserts; done pulses the cycle after start.
  - Divide path is unchanged at 33 cycles.
- Undefined: the iterative 33-cycle multiply above is used; no multiplier cells are inferred.

Test Plan:
- Reset then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 33 cycles, done one cycle, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-7 (0xFFFFFFF9), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF after 33 cycles; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated at each edge; busy and done stay 0.
- MULTU 5*6 started, second start (DIVU 9/2) while busy -> ignored, result hi=0, lo=30. Then start DIVU in the done cycle -> accepted, lo=4, hi=1 after 33 cycles.
- Assert rst at cycle 10 of a DIVU -> busy=0, done=0, hi=lo=0 immediately; no done pulse follows. Under MULDIV_FAST_MUL_EN, MULTU 5*6 -> lo=30 the cycle after start, busy never 1.
